sequenciador_jogada: RTL

- Move sequencer for the macro/micro (ultimate tic-tac-toe) board datapath; sits beside fluxo_dados in place of the basic control FSM.
- Per turn it does four things:
  - drives the macro/micro register enables and resets;
  - enforces the "forced macro" rule, where the next macro board is the micro cell just played;
  - rejects illegal button presses;
  - alternates players and applies a per-move timeout.
- Game-over is reported on pronto, with winner or timeout cause.

---
 rtl/sequenciador_jogada_pkg.sv | 27 ++
 rtl/sequenciador_jogada_contador_timeout.sv | 24 ++
 rtl/sequenciador_jogada.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sequenciador_jogada_pkg.sv
// Shared encodings for the ultimate tic-tac-toe move sequencer.
`timescale 1ns/1ps
package sequenciador_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    ESPERA_MACRO = 4'd2,
    REG_MACRO    = 4'd3,
    ESPERA_MICRO = 4'd4,
    REG_MICRO    = 4'd5,
    ESCREVE      = 4'd6,
    VERIFICA     = 4'd7,
    TROCA        = 4'd8,
    FORCA        = 4'd9,
    FIM          = 4'd10
  } estado_t;

  localparam logic       JOG_X        = 1'b0;
  localparam logic       JOG_O        = 1'b1;
  localparam logic [3:0] POS_INVALIDA = 4'd9;

  function automatic logic pos_ok(input logic [3:0] p);
    return p < POS_INVALIDA;
  endfunction

endpackage

// File: rtl/sequenciador_jogada_contador_timeout.sv
// Per-wait-state cycle counter; o_tc flags the last allowed cycle.
`timescale 1ns/1ps
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int CONT_W         = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CONT_W-1:0] r_cont;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_cont <= '0;
    else if (i_clr) r_cont <= '0;
    else if (i_en)  r_cont <= r_cont + 1'b1;
  end

  assign o_tc = (r_cont == CONT_W'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/sequenciador_jogada.sv
// Turn sequencer: macro/micro selection, forced-macro rule, player swap, timeout.
`timescale 1ns/1ps
module sequenciador_jogada
  import sequenciador_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int CONT_W         = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic [3:0] pos,
  input  logic [8:0] macro_livre,
  input  logic [8:0] micro_ocupado,
  input  logic       fim_jogo,
  output logic       zeraR_macro,
  output logic       zeraR_micro,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       sinal_macro,
  output logic       zeraEdge,
  output logic       registra_tabuleiro,
  output logic       jogador,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t    r_estado, w_prox;
  logic       r_jog, r_to, r_inv;
  logic [3:0] r_micro;
  logic       w_inv, w_to_set, w_tc, w_espera;
  logic       w_macro_ok, w_micro_ok;
  logic [15:0] w_livre, w_ocup;

  // Positions 9..15 read as closed/occupied so they can never be accepted.
  assign w_livre    = {7'h00, macro_livre};
  assign w_ocup     = {7'h7F, micro_ocupado};
  assign w_macro_ok = tem_jogada && pos_ok(pos) && w_livre[pos];
  assign w_micro_ok = tem_jogada && pos_ok(pos) && !w_ocup[pos];
  assign w_espera   = (r_estado == ESPERA_MACRO) || (r_estado == ESPERA_MICRO);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .CONT_W        (CONT_W)
  ) u_cont (
    .clock(clock),
    .reset(reset),
    .i_clr(!w_espera),
    .i_en (w_espera),
    .o_tc (w_tc)
  );

  always_comb begin
    w_prox   = r_estado;
    w_inv    = 1'b0;
    w_to_set = 1'b0;
    case (r_estado)
      INICIAL:      if (iniciar) w_prox = PREPARA;
      PREPARA:      w_prox = ESPERA_MACRO;
      ESPERA_MACRO: begin
        if (w_macro_ok)      w_prox = REG_MACRO;
        else if (w_tc)       begin w_prox = FIM; w_to_set = 1'b1; end
        else if (tem_jogada) w_inv = 1'b1;
      end
      REG_MACRO:    w_prox = ESPERA_MICRO;
      ESPERA_MICRO: begin
        if (w_micro_ok)      w_prox = REG_MICRO;
        else if (w_tc)       begin w_prox = FIM; w_to_set = 1'b1; end
        else if (tem_jogada) w_inv = 1'b1;
      end
      REG_MICRO:    w_prox = ESCREVE;
      ESCREVE:      w_prox = VERIFICA;
      VERIFICA:     w_prox = fim_jogo ? FIM : TROCA;
      TROCA:        w_prox = w_livre[r_micro] ? FORCA : ESPERA_MACRO;
      FORCA:        w_prox = ESPERA_MICRO;
      FIM:          if (iniciar) w_prox = PREPARA;
      default:      w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_jog    <= JOG_X;
      r_to     <= 1'b0;
      r_inv    <= 1'b0;
      r_micro  <= '0;
    end else begin
      r_estado <= w_prox;
      r_inv    <= w_inv;
      if (r_estado == PREPARA) begin
        r_jog <= JOG_X;
        r_to  <= 1'b0;
      end
      if (r_estado == TROCA) r_jog <= ~r_jog;
      if (w_to_set)          r_to  <= 1'b1;
      // Same value the datapath loads into its micro register next cycle.
      if (r_estado == ESPERA_MICRO && w_micro_ok) r_micro <= pos;
    end
  end

  assign zeraR_macro        = (r_estado == PREPARA);
  assign zeraR_micro        = (r_estado == PREPARA);
  assign zeraEdge           = (r_estado == PREPARA) || (r_estado == TROCA) || r_inv;
  assign registraR_macro    = (r_estado == REG_MACRO) || (r_estado == FORCA);
  assign sinal_macro        = (r_estado == FORCA);
  assign registraR_micro    = (r_estado == REG_MICRO);
  assign registra_tabuleiro = (r_estado == ESCREVE);
  assign jogar_macro        = (r_estado == ESPERA_MACRO);
  assign jogar_micro        = (r_estado == ESPERA_MICRO);
  assign pronto             = (r_estado == FIM);
  assign timeout            = r_to;
  assign jogador            = r_jog;
  assign db_estado          = r_estado;

endmodule
